// File: rtl/ssp_frame_master.sv
// SSP frame master: serialises one 16-bit {RA, WnR, DI} register command and captures the slave's 12-bit reply.
// Latency: Rsp_Vld rises LEAD + 32*CLK_DIV + TRAIL cycles after the accept edge, then GAP idle cycles follow.
// Backpressure: Req_Rdy is high only in IDLE. Requests seen at any other time are dropped, so the host holds Req_Vld.
//
// Ports:
//   Clk, Rst                       clock (rising edge) and asynchronous active-low reset
//   Req_Vld/Req_Rdy/RA/WnR/DI      host command handshake and payload
//   Rsp_Vld/Rsp_RA/Rsp_DO          one-cycle completion pulse with address and captured slave data
//   Busy                           frame sequencer is not idle
//   SSP_SSEL/SCK/MOSI/MISO         serial link to the SSP slave. All outputs come straight from flops.
module ssp_frame_master #(
    parameter int CLK_DIV = 4,  // SCK half-period in Clk cycles
    parameter int LEAD    = 2,  // SSEL assert to first SCK low phase
    parameter int TRAIL   = 2,  // last SCK fall to SSEL deassert
    parameter int GAP     = 4   // minimum SSEL-low cycles between frames
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req_Vld,
    output logic        Req_Rdy,
    input  logic [2:0]  Req_RA,
    input  logic        Req_WnR,
    input  logic [11:0] Req_DI,
    output logic        Rsp_Vld,
    output logic [2:0]  Rsp_RA,
    output logic [11:0] Rsp_DO,
    output logic        Busy,
    output logic        SSP_SSEL,
    output logic        SSP_SCK,
    output logic        SSP_MOSI,
    input  logic        SSP_MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } state_t;

    // Terminal counts for the shared phase counter.
    localparam logic [15:0] LEAD_LAST  = 16'(LEAD - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] TRAIL_LAST = 16'(TRAIL - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);

    state_t      state_q;
    logic [15:0] cnt_q;      // cycles spent in the current state or SCK half-period
    logic [3:0]  bit_q;      // index of the bit currently on the wire
    logic [14:0] tx_q;       // remaining frame bits, next bit in [14]
    logic [11:0] rx_q;       // last 12 MISO samples. The first 4 fall off the top.
    logic [2:0]  ra_q;       // address of the frame in flight
    logic        ssel_q;
    logic        sck_q;
    logic        mosi_q;
    logic        rsp_vld_q;
    logic [2:0]  rsp_ra_q;
    logic [11:0] rsp_do_q;

    logic [15:0] frame_d;

    // Frame word as it will appear on MOSI, MSB first.
    assign frame_d = {Req_RA, Req_WnR, Req_DI};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            ra_q      <= '0;
            ssel_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_ra_q  <= '0;
            rsp_do_q  <= '0;
        end else begin
            rsp_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req_Vld) begin
                        // Latch the whole command so the host is free to move on.
                        state_q <= ST_LEAD;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        ssel_q  <= 1'b1;
                        mosi_q  <= frame_d[15];
                        tx_q    <= frame_d[14:0];
                        ra_q    <= Req_RA;
                        rx_q    <= '0;
                    end
                end

                ST_LEAD: begin
                    if (cnt_q == LEAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!sck_q) begin
                            // Rising SCK: the slave's bit has been stable for a full low phase.
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[10:0], SSP_MISO};
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                // MOSI keeps bit 0 until SSEL drops.
                                state_q <= ST_TRAIL;
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                mosi_q <= tx_q[14];
                                tx_q   <= {tx_q[13:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_TRAIL: begin
                    if (cnt_q == TRAIL_LAST) begin
                        cnt_q     <= '0;
                        ssel_q    <= 1'b0;
                        mosi_q    <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        rsp_ra_q  <= ra_q;
                        rsp_do_q  <= rx_q;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                default: begin
                    // Unreachable encodings fall back to a quiet idle link.
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    ssel_q  <= 1'b0;
                    sck_q   <= 1'b0;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Req_Rdy  = (state_q == ST_IDLE);
    assign Busy     = (state_q != ST_IDLE);
    assign Rsp_Vld  = rsp_vld_q;
    assign Rsp_RA   = rsp_ra_q;
    assign Rsp_DO   = rsp_do_q;
    assign SSP_SSEL = ssel_q;
    assign SSP_SCK  = sck_q;
    assign SSP_MOSI = mosi_q;

endmodule
